// File: rtl/layer_serializer_if.sv
// Bundle between upstream neuron lanes, the layer serializer and the next-layer stream consumer.
// master drives the parallel lane results; slave is the serializer itself.
interface layer_serializer_if #(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned DATAWIDTH   = 16
);
    localparam int unsigned IdxW = $clog2(NUM_NEURONS);

    logic [NUM_NEURONS*DATAWIDTH-1:0] in_data;
    logic [NUM_NEURONS-1:0]           in_valid;
    logic [DATAWIDTH-1:0]             input_val;
    logic                             input_valid;
    logic                             busy;
    logic                             overrun;
    logic [IdxW-1:0]                  max_idx;
    logic                             max_valid;

    modport master (
        output in_data, in_valid,
        input  input_val, input_valid, busy, overrun, max_idx, max_valid
    );

    modport slave (
        input  in_data, in_valid,
        output input_val, input_valid, busy, overrun, max_idx, max_valid
    );
endinterface

// File: rtl/layer_serializer.sv
// Collects per-lane neuron results and replays them as a contiguous serial frame, lane 0 first.
// Optional argmax tracking over each emitted frame is enabled by LAYER_SERIALIZER_ARGMAX_EN.
module layer_serializer #(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned DATAWIDTH   = 16
) (
    input logic              clk,
    input logic              rst,
    layer_serializer_if.slave bus
);
    localparam int unsigned IdxW = $clog2(NUM_NEURONS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_NEURONS - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                 state_q, state_d;
    logic [DATAWIDTH-1:0]   cap_q    [NUM_NEURONS];
    logic [DATAWIDTH-1:0]   cap_d    [NUM_NEURONS];
    logic [DATAWIDTH-1:0]   shadow_q [NUM_NEURONS];
    logic [DATAWIDTH-1:0]   shadow_d [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] flag_q, flag_d;
    logic [IdxW-1:0]        idx_q, idx_d, idx_nxt;
    logic [DATAWIDTH-1:0]   val_q, val_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   transfer, last;

    assign transfer = (state_q == StIdle) && (&flag_q);
    assign last     = (state_q == StSend) && (idx_q == LastIdx);
    assign idx_nxt  = idx_q + IdxW'(1);

    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        shadow_d  = shadow_q;
        flag_d    = flag_q;
        idx_d     = idx_q;
        val_d     = val_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;

        // On the transfer edge the bank is cleared, so a same-edge pulse lands in the fresh bank.
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (transfer) begin
                flag_d[k] = bus.in_valid[k];
                if (bus.in_valid[k]) cap_d[k] = bus.in_data[k*DATAWIDTH +: DATAWIDTH];
            end else if (bus.in_valid[k]) begin
                if (flag_q[k]) begin
                    overrun_d = 1'b1;
                end else begin
                    flag_d[k] = 1'b1;
                    cap_d[k]  = bus.in_data[k*DATAWIDTH +: DATAWIDTH];
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (transfer) begin
                    shadow_d = cap_q;
                    state_d  = StSend;
                    idx_d    = '0;
                    val_d    = cap_q[0];
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            StSend: begin
                if (last) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    idx_d = idx_nxt;
                    val_d = shadow_q[idx_nxt];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            flag_q    <= '0;
            idx_q     <= '0;
            val_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                cap_q[k]    <= '0;
                shadow_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            shadow_q  <= shadow_d;
            flag_q    <= flag_d;
            idx_q     <= idx_d;
            val_q     <= val_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.input_val   = val_q;
    assign bus.input_valid = valid_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;

`ifdef LAYER_SERIALIZER_ARGMAX_EN
    logic [DATAWIDTH-1:0] run_max_q, run_max_d;
    logic [IdxW-1:0]      run_idx_q, run_idx_d;
    logic [IdxW-1:0]      max_idx_q, max_idx_d;
    logic                 max_valid_q, max_valid_d;
    logic                 better;

    // The presented value at idx 0 seeds the running maximum; strict compare keeps the lowest index.
    assign better = (idx_q == '0) || ($signed(val_q) > $signed(run_max_q));

    always_comb begin
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        max_idx_d   = max_idx_q;
        max_valid_d = 1'b0;
        if (state_q == StSend) begin
            if (better) begin
                run_max_d = val_q;
                run_idx_d = idx_q;
            end
            if (last) begin
                max_idx_d   = better ? idx_q : run_idx_q;
                max_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            run_max_q   <= '0;
            run_idx_q   <= '0;
            max_idx_q   <= '0;
            max_valid_q <= 1'b0;
        end else begin
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            max_idx_q   <= max_idx_d;
            max_valid_q <= max_valid_d;
        end
    end

    assign bus.max_idx   = max_idx_q;
    assign bus.max_valid = max_valid_q;
`else
    assign bus.max_idx   = '0;
    assign bus.max_valid = 1'b0;
`endif
endmodule

// File: tb/tb_layer_serializer.sv
// Directed bench for layer_serializer: reset, simultaneous/staggered capture, back-to-back frames,
// overrun and argmax reporting (argmax expectations follow LAYER_SERIALIZER_ARGMAX_EN).
module tb_layer_serializer;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    localparam bit ArgmaxEn = 1'b1;
`else
    localparam bit ArgmaxEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    layer_serializer_if #(.NUM_NEURONS(N), .DATAWIDTH(DW)) bus ();

    layer_serializer #(.NUM_NEURONS(N), .DATAWIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of lane inputs, aligned to the falling edge.
    task automatic set_in(input logic [3:0] m, input logic [15:0] d3, input logic [15:0] d2,
                          input logic [15:0] d1, input logic [15:0] d0);
        @(negedge clk);
        bus.in_valid = m;
        bus.in_data  = {d3, d2, d1, d0};
    endtask

    // Called at the falling edge after the completing pulse; expects a frame exp_wait cycles later.
    task automatic frame(input string tag, input int exp_wait, input logic [15:0] e0,
                         input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3,
                         input logic [1:0] exp_max);
        logic [15:0] e [4];
        int w;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        w = 0;
        @(negedge clk);
        while (!bus.input_valid && w < 20) begin
            w++;
            @(negedge clk);
        end
        check({tag, "_wait"}, w, exp_wait);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_val%0d", tag, i), bus.input_val, e[i]);
            check($sformatf("%s_vld%0d", tag, i), bus.input_valid, 1);
            check($sformatf("%s_busy%0d", tag, i), bus.busy, 1);
            @(negedge clk);
        end
        check({tag, "_end_vld"}, bus.input_valid, 0);
        check({tag, "_end_busy"}, bus.busy, 0);
        check({tag, "_end_hold"}, bus.input_val, e[3]);
        check({tag, "_maxv"}, bus.max_valid, ArgmaxEn);
        check({tag, "_maxi"}, bus.max_idx, ArgmaxEn ? exp_max : 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        bus.in_valid = 4'b1111;
        bus.in_data  = {16'h0040, 16'h0030, 16'h0020, 16'h0010};

        // Reset held with pulses present: nothing captured, all outputs clear.
        @(negedge clk);
        @(negedge clk);
        check("rst_vld", bus.input_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ovr", bus.overrun, 0);
        check("rst_maxv", bus.max_valid, 0);
        check("rst_val", bus.input_val, 0);
        rst = 1'b1;
        bus.in_valid = '0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.input_valid) cnt++;
        end
        check("rst_noframe", cnt, 0);

        // Simultaneous capture.
        set_in(4'b1111, 16'd40, 16'd30, 16'd20, 16'd10);
        set_in(4'b0000, 16'hdead, 16'hdead, 16'hdead, 16'hdead);
        frame("sim", 0, 16'd10, 16'd20, 16'd30, 16'd40, 2'd3);

        // Staggered arrival: lanes 2, 0, 3, 1.
        set_in(4'b0100, 16'hdead, 16'h0003, 16'hdead, 16'hdead);
        set_in(4'b0001, 16'hdead, 16'hdead, 16'hdead, 16'h0001);
        set_in(4'b1000, 16'h0004, 16'hdead, 16'hdead, 16'hdead);
        set_in(4'b0010, 16'hdead, 16'hdead, 16'h0002, 16'hdead);
        set_in(4'b0000, 16'hbeef, 16'hbeef, 16'hbeef, 16'hbeef);
        frame("stag", 0, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 2'd3);

        // Back-to-back: second bank completes while the first frame is being sent.
        set_in(4'b1111, 16'd40, 16'd30, 16'd20, 16'd10);
        set_in(4'b0000, 16'hdead, 16'hdead, 16'hdead, 16'hdead);
        fork
            frame("b2b_a", 0, 16'd10, 16'd20, 16'd30, 16'd40, 2'd3);
            begin
                set_in(4'b1111, 16'h0050, 16'h0200, 16'h0300, 16'h0100);
                set_in(4'b0000, 16'hdead, 16'hdead, 16'hdead, 16'hdead);
            end
        join
        frame("b2b_b", 0, 16'h0100, 16'h0300, 16'h0200, 16'h0050, 2'd1);
        check("b2b_ovr", bus.overrun, 0);

        // Overrun: lane 1 pulsed twice before the bank completes; first value wins.
        set_in(4'b0010, 16'hdead, 16'hdead, 16'h0005, 16'hdead);
        set_in(4'b0000, 16'hdead, 16'hdead, 16'hdead, 16'hdead);
        set_in(4'b0010, 16'hdead, 16'hdead, 16'h0009, 16'hdead);
        set_in(4'b0000, 16'hdead, 16'hdead, 16'hdead, 16'hdead);
        check("ovr_set", bus.overrun, 1);
        set_in(4'b1101, 16'h0001, 16'h0022, 16'h0009, 16'h0011);
        set_in(4'b0000, 16'hdead, 16'hdead, 16'hdead, 16'hdead);
        frame("ovr", 0, 16'h0011, 16'h0005, 16'h0022, 16'h0001, 2'd2);
        check("ovr_sticky", bus.overrun, 1);

        // Argmax with a negative lane and a tie between lanes 1 and 2.
        set_in(4'b1111, 16'h0002, 16'h0007, 16'h0007, 16'hfff0);
        set_in(4'b0000, 16'hdead, 16'hdead, 16'hdead, 16'hdead);
        frame("amax", 0, 16'hfff0, 16'h0007, 16'h0007, 16'h0002, 2'd1);
        @(negedge clk);
        check("amax_pulse_end", bus.max_valid, 0);
        check("amax_hold", bus.max_idx, ArgmaxEn ? 2'd1 : 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
